// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults and FSM state type for the systolic array stream adapters
package systolic_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_SIZE_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
endpackage

// File: rtl/wr_out_reg.sv
// wr_out_reg: single-entry valid/ready output register for buffer writes
module wr_out_reg
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_can_load,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);
  assign o_can_load = !o_valid || i_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_addr  <= i_addr;
      o_data  <= i_data;
      o_last  <= i_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/out_feature_writer.sv
// out_feature_writer: re-addresses channel-group-major result beats into an HWC output buffer
module out_feature_writer
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SIZE_W = DEF_SIZE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] out_size,
  input  logic [SIZE_W-1:0] ch_beats,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_last,
  output logic              busy,
  output logic              done
);
  localparam int PW = 2 * SIZE_W;
  state_t            r_state;
  logic [PW-1:0]     r_pix_total, r_p;
  logic [SIZE_W-1:0] r_ch, r_g;
  logic [ADDR_W-1:0] r_addr;
  logic              r_zero_done;
  logic              w_can_load, w_accept, w_pix_end, w_grp_end;
  assign s_ready   = (r_state == RUN) && w_can_load;
  assign w_accept  = s_valid && s_ready;
  assign w_pix_end = r_p == r_pix_total - PW'(1);
  assign w_grp_end = r_g == r_ch - SIZE_W'(1);
  assign busy      = r_state != IDLE;
  assign done      = r_zero_done || (r_state == FLUSH && wr_valid && wr_ready);
  // addr walks p*ch_beats + g incrementally; a group wrap restarts at the next channel group
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pix_total <= '0;
      r_p         <= '0;
      r_ch        <= '0;
      r_g         <= '0;
      r_addr      <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= 1'b0;
      if (r_state == IDLE && start) begin
        if (out_size == '0 || ch_beats == '0) begin
          r_zero_done <= 1'b1;
        end else begin
          r_state     <= RUN;
          r_ch        <= ch_beats;
          r_pix_total <= PW'(out_size) * PW'(out_size);
          r_p         <= '0;
          r_g         <= '0;
          r_addr      <= '0;
        end
      end else if (r_state == RUN && w_accept) begin
        if (w_pix_end) begin
          r_p    <= '0;
          r_g    <= r_g + SIZE_W'(1);
          r_addr <= ADDR_W'(r_g) + ADDR_W'(1);
          if (w_grp_end) r_state <= FLUSH;
        end else begin
          r_p    <= r_p + PW'(1);
          r_addr <= r_addr + ADDR_W'(r_ch);
        end
      end else if (r_state == FLUSH && wr_valid && wr_ready) begin
        r_state <= IDLE;
      end
    end
  end
  wr_out_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_out (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_addr     (r_addr),
    .i_data     (s_data),
    .i_last     (w_pix_end && w_grp_end),
    .i_ready    (wr_ready),
    .o_can_load (w_can_load),
    .o_valid    (wr_valid),
    .o_addr     (wr_addr),
    .o_data     (wr_data),
    .o_last     (wr_last)
  );
endmodule
